// File: rtl/riscv_pkg.sv
// Shared RISC-V encode/decode types: immediate-format codes,
// the canonical nop word and the stage-1 field bundle.
package riscv_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_U = 3'b011,
    IMM_J = 3'b100,
    IMM_R = 3'b111
  } imm_src_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [2:0]  src;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } fields_t;

endpackage

// File: rtl/instr_encoder_if.sv
// Field-set input and encoded-word output handshakes.
// slave: encoder side; master: field source / memory side.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  ImmSrc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [31:0] addr;
  logic        err;
  logic [7:0]  err_count;

  modport slave (
    input  in_valid, ImmSrc, opcode, funct3,
    input  funct7, rd, rs1, rs2, imm, out_ready,
    output in_ready, out_valid, instr, addr,
    output err, err_count
  );

  modport master (
    output in_valid, ImmSrc, opcode, funct3,
    output funct7, rd, rs1, rs2, imm, out_ready,
    input  in_ready, out_valid, instr, addr,
    input  err, err_count
  );
endinterface

// File: rtl/imm_pack.sv
// Combinational format table: i_f -> packed word o_instr,
// o_err when the immediate does not fit the format.
module imm_pack
  import riscv_pkg::*;
(
  input  fields_t     i_f,
  output logic [31:0] o_instr,
  output logic        o_err
);

  logic [31:0] w_imm;
  logic        w_fit12;
  logic        w_fit13;
  logic        w_fit21;

  assign w_imm   = i_f.imm;
  // upper bits must all be sign copies
  assign w_fit12 = &w_imm[31:11] | ~|w_imm[31:11];
  assign w_fit13 = &w_imm[31:12] | ~|w_imm[31:12];
  assign w_fit21 = &w_imm[31:20] | ~|w_imm[31:20];

  always_comb begin
    o_instr = NOP_INSTR;
    o_err   = 1'b1;
    unique case (1'b1)
      (i_f.src == IMM_I): begin
        o_instr = {w_imm[11:0], i_f.rs1,
                   i_f.funct3, i_f.rd, i_f.opcode};
        o_err   = !w_fit12;
      end
      (i_f.src == IMM_S): begin
        o_instr = {w_imm[11:5], i_f.rs2, i_f.rs1,
                   i_f.funct3, w_imm[4:0], i_f.opcode};
        o_err   = !w_fit12;
      end
      (i_f.src == IMM_B): begin
        o_instr = {w_imm[12], w_imm[10:5], i_f.rs2,
                   i_f.rs1, i_f.funct3, w_imm[4:1],
                   w_imm[11], i_f.opcode};
        o_err   = !w_fit13 | w_imm[0];
      end
      (i_f.src == IMM_U): begin
        o_instr = {w_imm[31:12], i_f.rd, i_f.opcode};
        o_err   = |w_imm[11:0];
      end
      (i_f.src == IMM_J): begin
        o_instr = {w_imm[20], w_imm[10:1], w_imm[11],
                   w_imm[19:12], i_f.rd, i_f.opcode};
        o_err   = !w_fit21 | w_imm[0];
      end
      (i_f.src == IMM_R): begin
        o_instr = {i_f.funct7, i_f.rs2, i_f.rs1,
                   i_f.funct3, i_f.rd, i_f.opcode};
        o_err   = 1'b0;
      end
      default: begin
        o_instr = NOP_INSTR;
        o_err   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage instruction encoder with write address and
// saturating error count. Ports: clk, reset_n, clear, bus.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input logic              clk,
  input logic              reset_n,
  input logic              clear,
  instr_encoder_if.slave   bus
);

  logic        w_en;
  logic        w_hs;
  fields_t     w_in;
  logic [31:0] w_instr;
  logic        w_err;

  logic        r_s1_valid;
  fields_t     r_s1;
  logic        r_out_valid;
  logic [31:0] r_instr;
  logic        r_err;
  logic [31:0] r_addr;
  logic [7:0]  r_err_count;

  assign w_en = !r_out_valid | bus.out_ready;
  assign w_hs = r_out_valid & bus.out_ready;

  assign w_in = '{
    src:    bus.ImmSrc,
    opcode: bus.opcode,
    funct3: bus.funct3,
    funct7: bus.funct7,
    rd:     bus.rd,
    rs1:    bus.rs1,
    rs2:    bus.rs2,
    imm:    bus.imm
  };

  assign bus.in_ready  = w_en & !clear;
  assign bus.out_valid = r_out_valid;
  assign bus.instr     = r_instr;
  assign bus.addr      = r_addr;
  assign bus.err       = r_err;
  assign bus.err_count = r_err_count;

  imm_pack u_pack (
    .i_f    (r_s1),
    .o_instr(w_instr),
    .o_err  (w_err)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (clear) begin
      r_s1_valid <= 1'b0;
    end else if (w_en) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) r_s1 <= w_in;
    end
  end

  // payload only moves with a real word so a bubble
  // leaves the last word's bits in place
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_instr     <= '0;
      r_err       <= 1'b0;
    end else if (clear) begin
      r_out_valid <= 1'b0;
    end else if (w_en) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_instr <= w_instr;
        r_err   <= w_err;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr      <= BASE_ADDR;
      r_err_count <= '0;
    end else if (clear) begin
      r_addr      <= BASE_ADDR;
      r_err_count <= '0;
    end else if (w_hs) begin
      r_addr <= r_addr + 32'd4;
      if (r_err && r_err_count != 8'hFF)
        r_err_count <= r_err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Random + directed bench for instr_encoder against a
// queue-based reference model of the format rules.
module tb_instr_encoder;
  import riscv_pkg::*;

  localparam logic [31:0] BASE = 32'hFFFF_FFF0;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clear = 1'b0;

  instr_encoder_if bus();

  instr_encoder #(.BASE_ADDR(BASE)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (clear),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  exp_t        q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] m_addr;
  int          m_cnt;

  logic        d_valid, d_ready, d_clear;
  logic [2:0]  d_src, d_f3;
  logic [6:0]  d_op, d_f7;
  logic [4:0]  d_rd, d_rs1, d_rs2;
  logic [31:0] d_imm;

  logic        prev_stall;
  logic [31:0] prev_instr, prev_addr;
  logic        prev_err;
  logic        last_ov, last_acc, last_hs;
  logic [31:0] hs_instr, hs_addr;
  logic        hs_err;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic exp_t ref_enc(
    logic [2:0] src, logic [6:0] op, logic [2:0] f3,
    logic [6:0] f7, logic [4:0] rd, logic [4:0] rs1,
    logic [4:0] rs2, logic [31:0] u);
    exp_t e;
    int   v;
    logic [31:0] base;
    v = $signed(u);
    base = 32'(op) | (32'(rd) << 7) | (32'(f3) << 12)
         | (32'(rs1) << 15);
    case (src)
      3'd0: begin
        e.instr = base | ((u & 32'hFFF) << 20);
        e.err = (v < -2048) || (v > 2047);
      end
      3'd1: begin
        e.instr = 32'(op) | (32'(f3) << 12)
                | (32'(rs1) << 15) | (32'(rs2) << 20)
                | ((u & 32'h1F) << 7)
                | (((u >> 5) & 32'h7F) << 25);
        e.err = (v < -2048) || (v > 2047);
      end
      3'd2: begin
        e.instr = 32'(op) | (32'(f3) << 12)
                | (32'(rs1) << 15) | (32'(rs2) << 20)
                | (((u >> 11) & 1) << 7)
                | (((u >> 1) & 32'hF) << 8)
                | (((u >> 5) & 32'h3F) << 25)
                | (((u >> 12) & 1) << 31);
        e.err = (v < -4096) || (v > 4095) || (u % 2 != 0);
      end
      3'd3: begin
        e.instr = (u & 32'hFFFF_F000) | 32'(op)
                | (32'(rd) << 7);
        e.err = (u % 4096) != 0;
      end
      3'd4: begin
        e.instr = 32'(op) | (32'(rd) << 7)
                | (((u >> 12) & 32'hFF) << 12)
                | (((u >> 11) & 1) << 20)
                | (((u >> 1) & 32'h3FF) << 21)
                | (((u >> 20) & 1) << 31);
        e.err = (v < -(1 << 20)) || (v >= (1 << 20))
             || (u % 2 != 0);
      end
      3'd7: begin
        e.instr = 32'(op) | (32'(rd) << 7)
                | (32'(f3) << 12) | (32'(rs1) << 15)
                | (32'(rs2) << 20) | (32'(f7) << 25);
        e.err = 1'b0;
      end
      default: begin
        e.instr = 32'h0000_0013;
        e.err = 1'b1;
      end
    endcase
    return e;
  endfunction

  task automatic model_reset();
    q.delete();
    m_addr = BASE;
    m_cnt = 0;
    prev_stall = 1'b0;
  endtask

  task automatic cycle();
    exp_t e;
    @(negedge clk);
    bus.in_valid  = d_valid;
    bus.ImmSrc    = d_src;
    bus.opcode    = d_op;
    bus.funct3    = d_f3;
    bus.funct7    = d_f7;
    bus.rd        = d_rd;
    bus.rs1       = d_rs1;
    bus.rs2       = d_rs2;
    bus.imm       = d_imm;
    bus.out_ready = d_ready;
    clear         = d_clear;
    #1;
    check("in_ready", 32'(bus.in_ready),
          32'((!bus.out_valid || d_ready) && !d_clear));
    if (prev_stall) begin
      check("stall_instr", bus.instr, prev_instr);
      check("stall_addr", bus.addr, prev_addr);
      check("stall_err", 32'(bus.err), 32'(prev_err));
    end
    last_ov  = bus.out_valid;
    last_acc = d_valid & bus.in_ready;
    last_hs  = bus.out_valid & d_ready;
    if (last_hs) begin
      hs_instr = bus.instr;
      hs_addr  = bus.addr;
      hs_err   = bus.err;
    end
    if (d_clear) begin
      model_reset();
    end else begin
      if (last_hs) begin
        if (q.size() == 0) begin
          check("spurious_word", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("instr", bus.instr, e.instr);
          check("err", 32'(bus.err), 32'(e.err));
          check("addr", bus.addr, m_addr);
          check("err_count", 32'(bus.err_count),
                32'(m_cnt));
          if (e.err && m_cnt < 255) m_cnt++;
        end
        m_addr = m_addr + 32'd4;
      end
      if (last_acc)
        q.push_back(ref_enc(d_src, d_op, d_f3, d_f7,
                            d_rd, d_rs1, d_rs2, d_imm));
      prev_stall = bus.out_valid & !d_ready;
      prev_instr = bus.instr;
      prev_addr  = bus.addr;
      prev_err   = bus.err;
    end
  endtask

  task automatic send(logic [2:0] src, logic [6:0] op,
                      logic [2:0] f3, logic [4:0] rd,
                      logic [4:0] rs1, logic [4:0] rs2,
                      logic [31:0] imm);
    bit ok = 0;
    d_src = src; d_op = op; d_f3 = f3; d_f7 = 7'h20;
    d_rd = rd; d_rs1 = rs1; d_rs2 = rs2; d_imm = imm;
    d_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      cycle();
      ok = last_acc;
    end
    d_valid = 1'b0;
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_hs(output int n);
    bit ok = 0;
    n = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      cycle();
      n++;
      ok = last_hs;
    end
    if (!ok) check("hs_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_reset_vals(string tag);
    check({tag, "_ov"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_instr"}, bus.instr, 32'd0);
    check({tag, "_err"}, 32'(bus.err), 32'd0);
    check({tag, "_addr"}, bus.addr, BASE);
    check({tag, "_cnt"}, 32'(bus.err_count), 32'd0);
  endtask

  function automatic logic [31:0] rnd_imm();
    logic [31:0] edges [10];
    edges = '{32'd2047, 32'd2048, -32'd2048, -32'd2049,
              32'd4094, 32'd4096, -32'd4096, 32'hFFFFF,
              32'h100000, -32'h100000};
    case ($urandom_range(0, 3))
      0: return 32'($urandom_range(0, 6000)) - 32'd3000;
      1: return $urandom();
      2: return edges[$urandom_range(0, 9)];
      default: return $urandom() & 32'hFFFF_F000;
    endcase
  endfunction

  int lat;

  initial begin
    d_valid = 0; d_ready = 1; d_clear = 0;
    d_src = 0; d_op = 0; d_f3 = 0; d_f7 = 0;
    d_rd = 0; d_rs1 = 0; d_rs2 = 0; d_imm = 0;
    bus.in_valid = 0; bus.out_ready = 1;
    bus.ImmSrc = 0; bus.opcode = 0; bus.funct3 = 0;
    bus.funct7 = 0; bus.rd = 0; bus.rs1 = 0;
    bus.rs2 = 0; bus.imm = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk_reset_vals("reset");
    reset_n = 1'b1;

    send(3'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    wait_hs(lat);
    check("I_latency", 32'(lat), 32'd2);
    check("I_instr", hs_instr, 32'h0050_0093);
    check("I_err", 32'(hs_err), 32'd0);
    check("I_addr", hs_addr, BASE);

    send(3'd1, 7'h23, 3'd2, 5'd0, 5'd0, 5'd2, 32'd8);
    wait_hs(lat);
    check("S_instr", hs_instr, 32'h0020_2423);
    check("S_addr", hs_addr, BASE + 32'd4);

    send(3'd4, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'd8);
    wait_hs(lat);
    check("J_instr", hs_instr, 32'h0080_00EF);

    send(3'd3, 7'h37, 3'd0, 5'd5, 5'd0, 5'd0,
         32'h1234_5000);
    wait_hs(lat);
    check("U_instr", hs_instr, 32'h1234_52B7);

    send(3'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    wait_hs(lat);
    check("Ierr_instr", hs_instr, 32'h8000_0093);
    check("Ierr_err", 32'(hs_err), 32'd1);
    check("wrap_addr", hs_addr, 32'd0);
    cycle();
    check("Ierr_cnt", 32'(bus.err_count), 32'd1);

    send(3'd2, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'd3);
    wait_hs(lat);
    check("B_odd_err", 32'(hs_err), 32'd1);

    send(3'd5, 7'h33, 3'd1, 5'd3, 5'd4, 5'd5, 32'd0);
    wait_hs(lat);
    check("illegal_instr", hs_instr, 32'h0000_0013);
    check("illegal_err", 32'(hs_err), 32'd1);

    // backpressure: third word blocked for three cycles
    d_ready = 1'b1;
    send(3'd7, 7'h33, 3'd0, 5'd1, 5'd2, 5'd3, 32'd0);
    send(3'd7, 7'h33, 3'd1, 5'd4, 5'd5, 5'd6, 32'd0);
    d_ready = 1'b0;
    d_src = 3'd7; d_rd = 5'd7; d_valid = 1'b1;
    repeat (3) begin
      cycle();
      check("bp_in_ready", 32'(last_acc), 32'd0);
    end
    d_ready = 1'b1;
    send(3'd7, 7'h33, 3'd2, 5'd7, 5'd8, 5'd9, 32'd0);
    repeat (4) cycle();
    check("bp_drain", 32'(q.size()), 32'd0);

    // clear with two words in flight
    d_ready = 1'b0;
    send(3'd0, 7'h13, 3'd0, 5'd1, 5'd1, 5'd0, 32'd1);
    send(3'd0, 7'h13, 3'd0, 5'd2, 5'd1, 5'd0, 32'd2);
    d_clear = 1'b1; d_valid = 1'b1;
    cycle();
    check("clr_no_accept", 32'(last_acc), 32'd0);
    d_clear = 1'b0; d_valid = 1'b0;
    cycle();
    check("clr_ov", 32'(last_ov), 32'd0);
    check("clr_addr", bus.addr, BASE);
    check("clr_cnt", 32'(bus.err_count), 32'd0);
    d_ready = 1'b1;
    repeat (3) cycle();
    check("clr_ov_stays", 32'(last_ov), 32'd0);

    // asynchronous reset during a stall
    d_ready = 1'b0;
    send(3'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd4095);
    send(3'd0, 7'h13, 3'd0, 5'd2, 5'd0, 5'd0, 32'd9);
    repeat (2) cycle();
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    d_ready = 1'b1;

    // saturation
    for (int i = 0; i < 260; i++)
      send(3'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    repeat (4) cycle();
    check("sat_cnt", 32'(bus.err_count), 32'd255);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      d_valid = ($urandom_range(0, 9) < 7);
      d_ready = ($urandom_range(0, 9) < 7);
      d_clear = ($urandom_range(0, 99) == 0);
      d_src = 3'($urandom_range(0, 7));
      d_op = 7'($urandom()); d_f3 = 3'($urandom());
      d_f7 = 7'($urandom()); d_rd = 5'($urandom());
      d_rs1 = 5'($urandom()); d_rs2 = 5'($urandom());
      d_imm = rnd_imm();
      cycle();
    end

    d_valid = 1'b0; d_ready = 1'b1; d_clear = 1'b0;
    repeat (6) cycle();
    check("final_drain", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
